// File: rtl/spi_rx_buffer.sv
// SPI-slave (mode 0) receive buffer: deserializes MOSI into DEPTH bytes clocked by spi_sclk alone.
// Optional sticky overrun flag is built when SPI_RX_BUFFER_OVERRUN_EN is defined.
module spi_rx_buffer #(
  parameter int DEPTH     = 4,
  parameter int LEN_WIDTH = 3
) (
  input  logic                 spi_sclk,
  input  logic                 spi_cs_n,
  input  logic                 spi_rx,
  output logic [7:0]           rx [DEPTH],
  input  logic [LEN_WIDTH-1:0] length,
  output logic                 done
`ifdef SPI_RX_BUFFER_OVERRUN_EN
  ,
  output logic                 overrun
`endif
);

  localparam logic [LEN_WIDTH-1:0] DEPTH_L = LEN_WIDTH'(DEPTH);
  localparam logic [LEN_WIDTH-1:0] ONE_L   = LEN_WIDTH'(1);

  logic [2:0]           bit_cnt;
  logic [LEN_WIDTH-1:0] byte_cnt;
  logic [6:0]           shreg;
  logic [7:0]           byte_in;
  logic                 byte_end;
  logic                 full;

  // byte_in is the completed byte on the 8th rise, so it lands in rx with no extra edge
  assign byte_in  = {shreg, spi_rx};
  assign byte_end = !spi_cs_n && (bit_cnt == 3'd7);
  assign full     = (byte_cnt == DEPTH_L);

  always_ff @(posedge spi_sclk) begin
    if (spi_cs_n) begin
      bit_cnt  <= 3'd0;
      byte_cnt <= '0;
      shreg    <= '0;
    end else begin
      shreg   <= byte_in[6:0];
      bit_cnt <= bit_cnt + 3'd1;
      if (byte_end && !full)
        byte_cnt <= byte_cnt + ONE_L;
    end
  end

  // rx has no reset so the last frame stays readable after spi_cs_n rises
  always_ff @(posedge spi_sclk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (byte_end && !full && (byte_cnt == LEN_WIDTH'(i)))
        rx[i] <= byte_in;
    end
  end

  assign done = (byte_cnt >= length) && (byte_cnt != '0);

`ifdef SPI_RX_BUFFER_OVERRUN_EN
  always_ff @(posedge spi_sclk) begin
    if (spi_cs_n)
      overrun <= 1'b0;
    else if (byte_end && full)
      overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_spi_rx_buffer.sv
// Scoreboard bench for spi_rx_buffer: stimulus pushes expected snapshots, a monitor pops and compares.
module tb_spi_rx_buffer;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          spi_sclk = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic          spi_rx   = 1'b0;
  logic [7:0]    rx [DEPTH];
  logic [LW-1:0] length   = 3'd4;
  logic          done;
`ifdef SPI_RX_BUFFER_OVERRUN_EN
  logic          overrun;
`endif

  spi_rx_buffer #(.DEPTH(DEPTH), .LEN_WIDTH(LW)) dut (
    .spi_sclk(spi_sclk),
    .spi_cs_n(spi_cs_n),
    .spi_rx  (spi_rx),
    .rx      (rx),
    .length  (length),
    .done    (done)
`ifdef SPI_RX_BUFFER_OVERRUN_EN
    ,
    .overrun (overrun)
`endif
  );

  int falls = 0;
  initial begin
    forever begin
      #10 spi_sclk = 1'b1;
      #10 spi_sclk = 1'b0;
      falls++;
    end
  end

  typedef struct {
    int                 due;
    int                 id;
    logic [8*DEPTH-1:0] rxv;
    logic               dn;
    logic               ov;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: bytes of the frame in arrival order, only the first DEPTH are kept
  logic [7:0] m_rx [DEPTH];
  int         m_cnt = 0;
  int         m_len = 4;

  function automatic logic [8*DEPTH-1:0] pack_model();
    logic [8*DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[8*i +: 8] = m_rx[i];
    return v;
  endfunction

  task automatic push_exp(input int due, input int id);
    exp_t e;
    int   kept;
    kept   = (m_cnt > DEPTH) ? DEPTH : m_cnt;
    e.due  = due;
    e.id   = id;
    e.rxv  = pack_model();
    e.dn   = (kept >= m_len) && (kept != 0);
    e.ov   = (m_cnt > DEPTH);
    q.push_back(e);
  endtask

  // Monitor: 1 ns after each falling edge, check everything due by now
  always @(negedge spi_sclk) begin
    exp_t               e;
    logic [8*DEPTH-1:0] act;
    #1;
    while (q.size() > 0 && q[0].due <= falls) begin
      e = q.pop_front();
      for (int i = 0; i < DEPTH; i++) act[8*i +: 8] = rx[i];
      tests++;
      if (act !== e.rxv) begin
        fails++;
        $display("FAIL rx id=%0d: got %h want %h", e.id, act, e.rxv);
      end
      tests++;
      if (done !== e.dn) begin
        fails++;
        $display("FAIL done id=%0d: got %b want %b", e.id, done, e.dn);
      end
`ifdef SPI_RX_BUFFER_OVERRUN_EN
      tests++;
      if (overrun !== e.ov) begin
        fails++;
        $display("FAIL overrun id=%0d: got %b want %b", e.id, overrun, e.ov);
      end
`endif
    end
  end

  int id_ctr = 0;

  task automatic drive_bit(input logic b);
    @(negedge spi_sclk);
    #2;
    spi_cs_n = 1'b0;
    spi_rx   = b;
  endtask

  // newlen < 0 keeps length; otherwise it changes together with the first bit
  task automatic send_byte(input logic [7:0] b, input int newlen);
    for (int i = 7; i >= 0; i--) begin
      drive_bit(b[i]);
      if (i == 7 && newlen >= 0) begin
        length = LW'(newlen);
        m_len  = newlen;
        push_exp(falls + 1, id_ctr++);
      end
    end
    if (m_cnt < DEPTH) m_rx[m_cnt] = b;
    m_cnt++;
    push_exp(falls + 1, id_ctr++);
  endtask

  task automatic partial(input int nbits);
    for (int i = 0; i < nbits; i++) drive_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic end_frame();
    @(negedge spi_sclk);
    #2;
    spi_cs_n = 1'b1;
    m_cnt    = 0;
    push_exp(falls + 1, id_ctr++);
    @(negedge spi_sclk);
  endtask

  task automatic set_len_idle(input int l);
    length = LW'(l);
    m_len  = l;
  endtask

  initial begin
    int nb;
    int wait_cnt;
    push_exp(1, id_ctr++);
    repeat (3) @(negedge spi_sclk);

    set_len_idle(4);
    send_byte(8'hAA, -1); send_byte(8'h55, -1);
    send_byte(8'hCC, -1); send_byte(8'h33, -1);
    end_frame();

    send_byte(8'h0F, -1); send_byte(8'hF0, -1);
    send_byte(8'h00, -1); send_byte(8'hFF, -1);
    end_frame();

    set_len_idle(1);
    send_byte(8'h01, -1);
    send_byte(8'h02, 4);
    send_byte(8'h03, -1); send_byte(8'h04, -1);
    end_frame();

    partial(5);
    end_frame();
    send_byte(8'hA5, 1);
    end_frame();

    set_len_idle(4);
    send_byte(8'h11, -1); send_byte(8'h22, -1); send_byte(8'h33, -1);
    send_byte(8'h44, -1); send_byte(8'h55, -1);
    end_frame();

    set_len_idle(0);
    partial(3);
    end_frame();

    for (int f = 0; f < 30; f++) begin
      set_len_idle($urandom_range(0, 7));
      nb = $urandom_range(0, 6);
      for (int k = 0; k < nb; k++)
        send_byte(8'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1);
      if ($urandom_range(0, 3) == 0) partial($urandom_range(1, 7));
      end_frame();
    end

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 50) begin
      @(negedge spi_sclk);
      wait_cnt++;
    end
    #5;
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending checks want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
